// File: rtl/return_address_stack.sv
// Return-address stack: a circular LIFO that feeds the RA operand of the
// instruction address generator. A call pushes PC_temp + 1, a return pops,
// and RA always shows the current top of stack (0 when empty).
//
// Build option: define RAS_OVERWRITE_EN so that a push while full overwrites
// the oldest entry. When it is left undefined, a push while full is dropped.
// Overflow is set in both builds.
module return_address_stack #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Push,
  input  logic              Pop,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] PC_temp,
  output logic [ADDR_W-1:0] RA,
  output logic              Empty,
  output logic              Full,
  output logic [PTR_W:0]    Count,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Return address of a call: next word after the caller, carry out dropped.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] tp_q, tp_d, tp_dec;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             is_empty, is_full;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  assign tp_dec   = tp_q - PTR_ONE;
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);

  // Next control state and storage write request; Reset beats Flush beats Push/Pop.
  always_comb begin
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    wr_data = next_addr(PC_temp);
    if (Reset || Flush) begin
      tp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (Push && Pop) begin
      if (is_empty) begin
        // Return on an empty stack followed by a call: the call still lands.
        wr_en  = 1'b1;
        wr_idx = tp_q;
        tp_d   = tp_q + PTR_ONE;
        cnt_d  = cnt_q + CNT_ONE;
        udf_d  = 1'b1;
      end else begin
        // Tail call: replace the top entry in place.
        wr_en  = 1'b1;
        wr_idx = tp_dec;
      end
    end else if (Push) begin
      if (is_full) begin
        ovf_d = 1'b1;
`ifdef RAS_OVERWRITE_EN
        // tp already points at the oldest entry once the ring is full.
        wr_en  = 1'b1;
        wr_idx = tp_q;
        tp_d   = tp_q + PTR_ONE;
`endif
      end else begin
        wr_en  = 1'b1;
        wr_idx = tp_q;
        tp_d   = tp_q + PTR_ONE;
        cnt_d  = cnt_q + CNT_ONE;
      end
    end else if (Pop) begin
      if (is_empty) begin
        udf_d = 1'b1;
      end else begin
        tp_d  = tp_dec;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Control registers: pointer, occupancy and sticky flags.
  always_ff @(posedge Clock) begin
    tp_q  <= tp_d;
    cnt_q <= cnt_d;
    ovf_q <= ovf_d;
    udf_q <= udf_d;
  end

  // Storage array; contents are never cleared.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign RA        = is_empty ? '0 : mem[tp_dec];
  assign Empty     = is_empty;
  assign Full      = is_full;
  assign Count     = cnt_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Testbench for return_address_stack: directed call/return sequences plus
// randomized traffic, compared against a queue-based stack model.
module tb_return_address_stack;

  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int ADDR_W = 32;

  logic              Clock = 1'b0;
  logic              Reset, Push, Pop, Flush;
  logic [ADDR_W-1:0] PC_temp;
  logic [ADDR_W-1:0] RA;
  logic              Empty, Full, Overflow, Underflow;
  logic [PTR_W:0]    Count;

  return_address_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .Push(Push), .Pop(Pop), .Flush(Flush),
    .PC_temp(PC_temp), .RA(RA), .Empty(Empty), .Full(Full), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [ADDR_W-1:0] ra;
    int unsigned       cnt;
    logic              empty, full, ovf, udf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain queue, oldest entry at the front.
  logic [ADDR_W-1:0] stk[$];
  logic              m_ovf = 1'b0, m_udf = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [ADDR_W-1:0] got, input logic [ADDR_W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, want, $time);
  endtask

  task automatic model_step(input bit rst, input bit fl, input bit pu, input bit po,
                            input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] v;
    exp_t e;
    v = pc + 1;
    if (rst || fl) begin
      stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (pu && po) begin
      if (stk.size() > 0) stk[stk.size()-1] = v;
      else begin
        stk.push_back(v);
        m_udf = 1'b1;
      end
    end else if (pu) begin
      if (stk.size() == DEPTH) begin
        m_ovf = 1'b1;
`ifdef RAS_OVERWRITE_EN
        void'(stk.pop_front());
        stk.push_back(v);
`endif
      end else stk.push_back(v);
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_udf = 1'b1;
    end
    e.ra    = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    e.cnt   = stk.size();
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEPTH);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and record what the stack should show after the edge.
  task automatic step(input bit rst, input bit fl, input bit pu, input bit po,
                      input logic [ADDR_W-1:0] pc);
    @(negedge Clock);
    Reset = rst; Flush = fl; Push = pu; Pop = po; PC_temp = pc;
    @(posedge Clock);
    model_step(rst, fl, pu, po, pc);
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc); step(0, 0, 1, 0, pc); endtask
  task automatic pop();                             step(0, 0, 0, 1, '0); endtask
  task automatic flush();                           step(0, 1, 0, 0, '0); endtask

  // Monitor: after every edge with a pending expectation, compare all outputs.
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("RA",        RA,                    e.ra);
      chk("Count",     ADDR_W'(Count),        ADDR_W'(e.cnt));
      chk("Empty",     ADDR_W'(Empty),        ADDR_W'(e.empty));
      chk("Full",      ADDR_W'(Full),         ADDR_W'(e.full));
      chk("Overflow",  ADDR_W'(Overflow),     ADDR_W'(e.ovf));
      chk("Underflow", ADDR_W'(Underflow),    ADDR_W'(e.udf));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected run to complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Push = 1'b0; Pop = 1'b0; Flush = 1'b0; PC_temp = '0;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);

    // Single call and return.
    push(32'h10);
    pop();

    // Nested calls unwound in order.
    push(32'h100); push(32'h200); push(32'h300);
    pop(); pop(); pop();

    // Underflow is sticky until flush.
    pop();
    push(32'h40);
    flush();

    // Tail call replaces the top entry.
    push(32'h10); push(32'h20);
    step(0, 0, 1, 1, 32'h80);
    pop(); pop();
    // Push and pop together on an empty stack.
    step(0, 0, 1, 1, 32'h55);
    flush();

    // Overfill, drain, address wrap.
    for (int i = 0; i <= DEPTH; i++) push(ADDR_W'(i));
    for (int i = 0; i < DEPTH; i++) pop();
    push(32'hFFFF_FFFF);
    pop();
    pop();
    flush();

    // Reset while pushing mid-sequence.
    for (int i = 0; i < 5; i++) push(32'h1000 + ADDR_W'(i));
    step(1, 0, 1, 0, 32'h7777);
    pop();
    push(32'h2000);
    pop();
    pop();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit rst, fl, pu, po;
      logic [ADDR_W-1:0] pc;
      rst = ($urandom_range(0, 79) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      pu  = ($urandom_range(0, 99) < 55);
      po  = ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 9))
        0:       pc = 32'hFFFF_FFFF;
        1:       pc = '0;
        default: pc = $urandom;
      endcase
      step(rst, fl, pu, po, pc);
    end

    @(negedge Clock);
    Reset = 1'b0; Push = 1'b0; Pop = 1'b0; Flush = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
